// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU/loader constants: opcodes, loader states, error codes
// Purpose : opcode values (shared with the CPU decoder), the loader FSM state
//           encoding, the loader error codes and an opcode legality helper.
// Ports   : none (package).
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b111111;
  localparam logic [5:0] OP_ADDI  = 6'b110111;
  localparam logic [5:0] OP_BEQ   = 6'b111011;
  localparam logic [5:0] OP_ORI   = 6'b110010;
  localparam logic [5:0] OP_LUI   = 6'b110000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } loader_state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_OPC  = 2'b10;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_BEQ) ||
           (op == OP_ORI)   || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - byte-stream input and instruction-memory write bus
// Purpose : bundles the host byte link and the instruction memory write port.
// Signals : byte_valid_i/byte_data_i/byte_ready_o  host byte handshake
//           mem_we_o/mem_addr_o/mem_data_o         memory write port
// Modports: slave  - the loader (consumes bytes, drives memory writes)
//           master - the host/memory side
interface instr_mem_loader_if #(
  parameter int ADDR_W = 5
);

  logic              byte_valid_i;
  logic [7:0]        byte_data_i;
  logic              byte_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_data_o;

  modport slave (
    input  byte_valid_i,
    input  byte_data_i,
    output byte_ready_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_data_o
  );

  modport master (
    output byte_valid_i,
    output byte_data_i,
    input  byte_ready_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_data_o
  );

endinterface

// File: rtl/instr_mem_loader_word_packer.sv
// rtl/instr_mem_loader_word_packer.sv - packs four big-endian bytes into a 32-bit word
// Purpose : byte shift register plus 2-bit byte index.
// Ports   : clk_i, rst_i      clock, synchronous active-high reset
//           clr_i             discard partial word and index
//           shift_i           a byte is accepted this cycle
//           byte_i            accepted byte
//           word_o            first three stored bytes followed by byte_i
//           word_valid_o      the 4th byte of a word is accepted this cycle
module word_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  // Only three bytes need storage; the fourth arrives on byte_i in the
  // cycle the word completes, so the loader can register it directly.
  logic [23:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clr_i) begin
      word_d = '0;
      idx_d  = '0;
    end else if (shift_i) begin
      word_d = {word_q[15:0], byte_i};
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign word_o       = {word_q, byte_i};
  assign word_valid_o = shift_i && (idx_q == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - byte-stream loader for the instruction memory
// Purpose : packs a host byte stream into 32-bit words, writes them from word 0,
//           holds the CPU in reset while loading and releases it once an
//           all-zero terminator word has been written.
// Option  : LOADER_OPCHECK_EN - reject non-zero words with an unknown opcode.
// Ports   : clk_i, rst_i      clock, synchronous active-high reset
//           start_i           begin a load (honoured in IDLE/DONE/ERR)
//           bus (slave)       byte handshake in, memory write port out
//           cpu_rst_n_o       CPU reset, high only in DONE
//           busy_o            loading or writing
//           done_o, err_o     terminal status levels
//           err_code_o        00 none, 01 overflow, 10 illegal opcode
//           words_o           words written including the terminator
module instr_mem_loader
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  instr_mem_loader_if.slave   bus,
  output logic                cpu_rst_n_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [1:0]          err_code_o,
  output logic [ADDR_W:0]     words_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loader_state_e     state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   words_q;
  logic [1:0]        err_code_q;
  logic              done_q;
  logic              err_q;
  logic              cpu_rst_n_q;
  logic              busy_q;
  logic              ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_data_q;

  logic        accept;
  logic        start_ok;
  logic [31:0] word;
  logic        word_valid;

  // ready_q is high exactly while in LOAD, so it doubles as the LOAD flag.
  assign accept   = bus.byte_valid_i && ready_q;
  assign start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                (state_q == S_ERR));

  word_packer u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (start_ok),
    .shift_i     (accept),
    .byte_i      (bus.byte_data_i),
    .word_o      (word),
    .word_valid_o(word_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      words_q     <= '0;
      err_code_q  <= ERR_NONE;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      mem_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state_q     <= S_LOAD;
            addr_q      <= '0;
            words_q     <= '0;
            err_code_q  <= ERR_NONE;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            ready_q     <= 1'b1;
          end
        end

        S_LOAD: begin
          if (word_valid) begin
`ifdef LOADER_OPCHECK_EN
            if ((word != 32'd0) && !op_is_legal(word[31:26])) begin
              state_q    <= S_ERR;
              err_q      <= 1'b1;
              err_code_q <= ERR_OPC;
              busy_q     <= 1'b0;
              ready_q    <= 1'b0;
            end else begin
              state_q    <= S_WRITE;
              mem_we_q   <= 1'b1;
              mem_addr_q <= addr_q;
              mem_data_q <= word;
              ready_q    <= 1'b0;
            end
`else
            state_q    <= S_WRITE;
            mem_we_q   <= 1'b1;
            mem_addr_q <= addr_q;
            mem_data_q <= word;
            ready_q    <= 1'b0;
`endif
          end
        end

        S_WRITE: begin
          words_q <= words_q + 1'b1;
          // The terminator wins over overflow: a zero word in the last slot
          // is a complete program, not an overrun.
          if (mem_data_q == 32'd0) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            cpu_rst_n_q <= 1'b1;
            busy_q      <= 1'b0;
          end else if (addr_q == LAST_ADDR) begin
            state_q    <= S_ERR;
            err_q      <= 1'b1;
            err_code_q <= ERR_OVF;
            busy_q     <= 1'b0;
          end else begin
            state_q <= S_LOAD;
            addr_q  <= addr_q + 1'b1;
            ready_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready_o = ready_q;
  assign bus.mem_we_o     = mem_we_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;
  assign cpu_rst_n_o      = cpu_rst_n_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign err_code_o       = err_code_q;
  assign words_o          = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;
`ifdef LOADER_OPCHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cpu_rst_n, busy, done, err;
  logic [1:0] err_code;
  logic [ADDR_W:0] words;

  instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .bus        (bus),
    .cpu_rst_n_o(cpu_rst_n),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .err_code_o (err_code),
    .words_o    (words)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] legal_ops [5];
  logic [ADDR_W+31:0] wr_q [$];
  logic [31:0] stim_q [$];

  always @(negedge clk) if (bus.mem_we_o) wr_q.push_back({bus.mem_addr_o, bus.mem_data_o});

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    for (int k = 0; k < 5; k++) if (legal_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    int t = 0;
    @(negedge clk);
    bus.byte_valid_i = 1'b1;
    bus.byte_data_i  = b;
    while (!bus.byte_ready_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    ok = bus.byte_ready_o;
    if (ok) begin
      @(posedge clk);
      #1;
    end
    bus.byte_valid_i = 1'b0;
  endtask

  // Runs one load of stim_q and compares against the rules: words are written
  // from address 0 until a zero word (done), the last slot (overflow) or, with
  // the opcode check, an unknown opcode (error without a write).
  task automatic run_load(input int gap, input bit mid_start);
    logic [ADDR_W+31:0] exp_wr [$];
    bit exp_done, exp_err, ok;
    logic [1:0] exp_code;
    logic [31:0] w;
    int used;
    exp_done = 0; exp_err = 0; exp_code = 2'b00; used = 0;
    for (int i = 0; i < stim_q.size(); i++) begin
      w = stim_q[i];
      used = i + 1;
      if (OPCHK && w != 0 && !is_legal(w[31:26])) begin
        exp_err = 1; exp_code = 2'b10; break;
      end
      exp_wr.push_back({ADDR_W'(i), w});
      if (w == 0) begin exp_done = 1; break; end
      if (i == DEPTH - 1) begin exp_err = 1; exp_code = 2'b01; break; end
    end

    wr_q.delete();
    pulse_start();
    for (int i = 0; i < used; i++) begin
      w = stim_q[i];
      for (int b = 0; b < 4; b++) begin
        send_byte(w[31-8*b -: 8], ok);
        chk("byte_accepted", ok, 1);
        if (i == used - 1 && b == 3) break;
        repeat (gap) begin
          @(negedge clk);
          if (b < 3) chk("ready_in_gap", bus.byte_ready_o, 1);
        end
      end
      if (mid_start && i == 0 && used > 1) begin
        @(negedge clk);
        pulse_start();
      end
    end
    @(negedge clk);
    chk("we_after_last", bus.mem_we_o, exp_code != 2'b10);
    chk("cpu_rst_n_n1", cpu_rst_n, 0);
    @(negedge clk);
    chk("done", done, exp_done);
    chk("err", err, exp_err);
    chk("err_code", err_code, exp_code);
    chk("cpu_rst_n", cpu_rst_n, exp_done);
    chk("busy", busy, 0);
    chk("words", words, exp_wr.size());
    if (used < stim_q.size()) begin
      @(negedge clk);
      bus.byte_valid_i = 1'b1;
      bus.byte_data_i  = 8'hA5;
      repeat (3) @(negedge clk);
      chk("ready_after_stop", bus.byte_ready_o, 0);
      bus.byte_valid_i = 1'b0;
      @(negedge clk);
    end
    chk("n_writes", wr_q.size(), exp_wr.size());
    for (int k = 0; k < exp_wr.size() && k < wr_q.size(); k++)
      chk("write_addr_data", wr_q[k], exp_wr[k]);
  endtask

  initial begin
    logic [31:0] w, r;
    logic [5:0] op;
    bit ok;
    legal_ops[0] = 6'b111111; legal_ops[1] = 6'b110111; legal_ops[2] = 6'b111011;
    legal_ops[3] = 6'b110010; legal_ops[4] = 6'b110000;
    bus.byte_valid_i = 1'b0;
    bus.byte_data_i  = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_we", bus.mem_we_o, 0);
    chk("rst_ready", bus.byte_ready_o, 0);
    chk("rst_addr", bus.mem_addr_o, 0);
    chk("rst_data", bus.mem_data_o, 0);
    chk("rst_cpu_rst_n", cpu_rst_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_words", words, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", bus.byte_ready_o, 0);

    stim_q = {32'hDC010005, 32'hDC020003, 32'hFC221012, 32'h00000000};
    run_load(0, 0);
    run_load(3, 0);

    // Restart from DONE
    pulse_start();
    chk("restart_cpu_rst_n", cpu_rst_n, 0);
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    stim_q = {32'hDC010005, 32'h37000001, 32'h00000000};
    run_load(1, 1);

    // Overflow: four non-zero words then a fifth
    stim_q = {32'hFC000001, 32'hDC000002, 32'hEC000003, 32'hC8000004, 32'hC0000005, 32'h0};
    run_load(0, 1);

    // Unknown opcode
    stim_q = {32'h04000000, 32'hDC000001, 32'h00000000};
    run_load(0, 0);

    // Reset after two bytes of a word
    wr_q.delete();
    pulse_start();
    send_byte(8'hDC, ok);
    send_byte(8'h01, ok);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", bus.byte_ready_o, 0);
    chk("midrst_cpu_rst_n", cpu_rst_n, 0);
    chk("midrst_words", words, 0);
    chk("midrst_nwr", wr_q.size(), 0);
    stim_q = {32'hDC010005, 32'h00000000};
    run_load(0, 0);

    for (int n = 0; n < 30; n++) begin
      stim_q.delete();
      for (int i = 0; i < $urandom_range(1, 5); i++) begin
        r = $urandom_range(0, 99);
        w = $urandom;
        if (r < 15) w = 32'd0;
        else if (r < 30) begin
          op = 6'($urandom_range(0, 63));
          while (is_legal(op)) op = op + 6'd1;
          w[31:26] = op;
        end else w[31:26] = legal_ops[$urandom_range(0, 4)];
        stim_q.push_back(w);
      end
      stim_q.push_back(32'd0);
      run_load($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
